// File: rtl/test_dout.sv
// test_dout: FIFO-buffered valid-only stream transmitter with a programmable idle gap between beats.
// Optional tx_count beat counter enabled by defining TEST_DOUT_CNT_EN.
module test_dout #(
   parameter int DWIDTH = 16,
   parameter int DEPTH  = 8,
   parameter int GAP    = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DWIDTH-1:0]        in_data,
   output logic                     dout_valid,
   output logic [DWIDTH-1:0]        dout_data,
   output logic [$clog2(DEPTH):0]   level
`ifdef TEST_DOUT_CNT_EN
   ,
   output logic [31:0]              tx_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int GW = $clog2(GAP + 2);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
   typedef enum logic {IDLE, GAPWAIT} state_t;
   state_t state, state_nx;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [DWIDTH-1:0] mem [DEPTH];
   logic [GW-1:0] gap_cnt;
   logic push, pop;
   // Full blocks writes even when a pop happens the same cycle: no bypass path.
   assign in_ready = level != FULL;
   assign push = in_valid && in_ready;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = (state == IDLE) ? ((pop && GAP > 0) ? GAPWAIT : IDLE)
                                 : ((gap_cnt == GW'(1)) ? IDLE : GAPWAIT);
   always_comb
      pop = (state == IDLE) && (level != '0);
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= in_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         gap_cnt    <= '0;
         dout_valid <= 1'b0;
         dout_data  <= '0;
      end else begin
         wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
         level      <= (push && !pop) ? level + (AW + 1)'(1) :
                       (!push && pop) ? level - (AW + 1)'(1) : level;
         gap_cnt    <= pop ? GW'(GAP) : (state == GAPWAIT) ? gap_cnt - GW'(1) : gap_cnt;
         dout_valid <= pop;
         dout_data  <= pop ? mem[rd_ptr] : dout_data;
      end
`ifdef TEST_DOUT_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) tx_count <= '0;
      else if (dout_valid) tx_count <= tx_count + 32'd1;
`endif
endmodule

// File: tb/tb_test_dout.sv
// tb_test_dout: directed bench for test_dout with one GAP=0 and one GAP=3 instance.
module tb_test_dout;
   logic clk = 1'b0;
   logic rst_n;
   logic v0, r0, dv0, v3, r3, dv3;
   logic [15:0] d0, dd0, d3, dd3;
   logic [3:0] l0, l3;
`ifdef TEST_DOUT_CNT_EN
   logic [31:0] tc0, tc3;
`endif
   int n = 0;
   int err = 0;
   always #5 clk = ~clk;
   test_dout #(.DWIDTH(16), .DEPTH(8), .GAP(0)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .in_data(d0),
      .dout_valid(dv0), .dout_data(dd0), .level(l0)
`ifdef TEST_DOUT_CNT_EN
      , .tx_count(tc0)
`endif
   );
   test_dout #(.DWIDTH(16), .DEPTH(8), .GAP(3)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3), .in_data(d3),
      .dout_valid(dv3), .dout_data(dd3), .level(l3)
`ifdef TEST_DOUT_CNT_EN
      , .tx_count(tc3)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int j, k, last, beats_after;
      bit acc, saw_full;
`ifdef TEST_DOUT_CNT_EN
      logic [31:0] t0;
`endif
      rst_n = 1'b0; v0 = 1'b1; d0 = 16'hFFFF; v3 = 1'b1; d3 = 16'hFFFF;
      repeat (3) step();
      chk("rst_dout_valid", {31'd0, dv0}, 0);
      chk("rst_dout_data", {16'd0, dd0}, 0);
      chk("rst_level", {28'd0, l0}, 0);
      chk("rst_in_ready", {31'd0, r0}, 1);
      chk("rst_level_g3", {28'd0, l3}, 0);
      v0 = 1'b0; v3 = 1'b0;
      #2 rst_n = 1'b1;
      step();
      chk("post_rst_level", {28'd0, l0}, 0);
      // single-word latency, GAP=0
      v0 = 1'b1; d0 = 16'hA5A5;
      step();
      v0 = 1'b0;
      chk("lat_level_after_write", {28'd0, l0}, 1);
      chk("lat_valid_early", {31'd0, dv0}, 0);
      step();
      chk("lat_valid", {31'd0, dv0}, 1);
      chk("lat_data", {16'd0, dd0}, 32'hA5A5);
      chk("lat_level_empty", {28'd0, l0}, 0);
      step();
      chk("lat_valid_one_cycle", {31'd0, dv0}, 0);
      chk("lat_data_hold", {16'd0, dd0}, 32'hA5A5);
      // back-to-back streaming, GAP=0
`ifdef TEST_DOUT_CNT_EN
      t0 = tc0;
`endif
      for (int i = 0; i <= 16; i++) begin
         v0 = (i < 16);
         d0 = 16'(i + 1);
         step();
         chk("stream_in_ready", {31'd0, r0}, 1);
         if (i >= 1) begin
            chk("stream_valid", {31'd0, dv0}, 1);
            chk("stream_data", {16'd0, dd0}, 32'(i));
         end
      end
      v0 = 1'b0;
      step();
      chk("stream_end_valid", {31'd0, dv0}, 0);
      chk("stream_end_level", {28'd0, l0}, 0);
`ifdef TEST_DOUT_CNT_EN
      chk("stream_tx_count", tc0 - t0, 16);
`endif
      // fill and pacing, GAP=3
      j = 0; k = 0; last = -1; saw_full = 0;
      for (int c = 0; c < 80; c++) begin
         v3 = (j < 12);
         d3 = 16'(16'h0100 + j);
         acc = v3 && r3;
         step();
         if (acc) j++;
         if (l3 == 4'd8) saw_full = 1;
         chk("pace_in_ready", {31'd0, r3}, {31'd0, l3 != 4'd8});
         if (dv3) begin
            chk("pace_data", {16'd0, dd3}, 32'h0100 + 32'(k));
            if (last >= 0) chk("pace_spacing", 32'(c - last), 4);
            last = c;
            k++;
         end
      end
      v3 = 1'b0;
      chk("pace_words_written", 32'(j), 12);
      chk("pace_words_out", 32'(k), 12);
      chk("pace_saw_full", {31'd0, saw_full}, 1);
      chk("pace_level_end", {28'd0, l3}, 0);
      // mid-operation reset, GAP=3: 8 writes, then idle until the third beat
      for (int i = 0; i < 10; i++) begin
         v3 = (i < 8);
         d3 = 16'(16'h0200 + i);
         step();
      end
      v3 = 1'b0;
      chk("mid_level_before", {28'd0, l3}, 5);
      chk("mid_valid_before", {31'd0, dv3}, 1);
      chk("mid_data_before", {16'd0, dd3}, 32'h0202);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_async_valid", {31'd0, dv3}, 0);
      chk("mid_async_level", {28'd0, l3}, 0);
      chk("mid_async_data", {16'd0, dd3}, 0);
      chk("mid_async_ready", {31'd0, r3}, 1);
      #1 rst_n = 1'b1;
      beats_after = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (dv3) beats_after++;
      end
      chk("mid_no_stale_beats", 32'(beats_after), 0);
      chk("mid_level_idle", {28'd0, l3}, 0);
      v3 = 1'b1; d3 = 16'h02AA;
      step();
      v3 = 1'b0;
      step();
      chk("mid_new_valid", {31'd0, dv3}, 1);
      chk("mid_new_data", {16'd0, dd3}, 32'h02AA);
      $display("== %0d vectors applied, %0d miscompares ==", n, err);
      $finish;
   end
endmodule

// File: doc/test_dout.md
Name: test_dout

Overview:
- Stream transmitter; the source end of the valid-only `din_valid`/`din_data` stream consumed by `test_din`.
- Accepts words from a host-side ready/valid interface and buffers them in a small synchronous FIFO.
- Replays them in order as a valid-only output stream with no backpressure.
- Inserts a programmable minimum idle gap between output beats so slow sinks can be paced.

Parameters:
- DWIDTH, 16, data word width; must match the sink's DWIDTH.
- DEPTH, 8, FIFO depth in words; power of 2, ≥2.
- GAP, 0, idle cycles forced after every output beat; 0 = back-to-back beats allowed.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset; async assert, sync release by the system.
- in_valid  input  1  host word valid.
- in_ready  output  1  FIFO can accept a word this cycle.
- in_data  input  DWIDTH  host word.
- dout_valid  output  1  output beat valid; one cycle per word.
- dout_data  output  DWIDTH  output word; meaningful only when dout_valid=1.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO pointers and level cleared to 0; buffered contents discarded.
  - dout_valid=0, dout_data=0, gap counter=0, state=IDLE.
  - in_ready=1 while in reset.
- Input handshake:
  - in_ready = (level != DEPTH), taken from the registered level.
  - A word is written when in_valid && in_ready at a rising edge.
  - When full, no write occurs even if a pop happens the same cycle (conservative, no bypass).
  - in_data is ignored when in_valid=0.
- FIFO:
  - Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - level is incremented by a write and decremented by a pop; a simultaneous write and pop leaves it unchanged.
  - level never exceeds DEPTH and never underflows.
- State machine, IDLE / GAPWAIT:
  - IDLE: at an edge where level≠0, pop the head word and register dout_data<=head and dout_valid<=1.
    - If GAP>0, load gap_cnt<=GAP and go to GAPWAIT.
    - If GAP=0, stay in IDLE; the next pop may occur on the following edge, giving back-to-back beats.
  - GAPWAIT: dout_valid<=0. Decrement gap_cnt each edge; when gap_cnt reaches 1, return to IDLE.
- Beat spacing:
  - dout_valid is high for exactly one cycle per word.
  - Consecutive beats are separated by exactly GAP low cycles while the FIFO stays non-empty, and by at least GAP cycles otherwise.
- dout_data holds the last transmitted word while dout_valid=0 and is never cleared except by reset.
- Latency: a word accepted at edge k into an empty FIFO with state IDLE gives dout_valid=1 in the cycle after edge k+1, i.e. 2 cycles from in_valid to dout_valid.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Reset mid-operation: all buffered words are lost. After release, output resumes only with newly written words; there are no stale beats.

Optional Feature:
- Macro: TEST_DOUT_CNT_EN.
- Defined:
  - Adds output port tx_count [31:0], reset to 0, incremented on every cycle with dout_valid=1.
  - Wraps from 0xFFFF_FFFF to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → dout_valid=0, dout_data=0, level=0, in_ready=1, and nothing is written.
- Latency, GAP=0: single write of 0xA5A5 at cycle c → dout_valid=1 only in cycle c+2 with dout_data=0xA5A5; level returns to 0.
- Streaming, GAP=0: write 0x0001..0x0010 on 16 consecutive cycles → 16 consecutive dout_valid cycles carrying 0x0001..0x0010 in order; in_ready stays 1 throughout.
- Full and pacing, GAP=3, DEPTH=8: hold in_valid with 12 words 0x0100..0x010B →
  - in_ready drops when level=8;
  - beats occur every 4 cycles with exactly 3 low cycles between them;
  - all 12 words arrive in order and none are lost.
- Reset mid-operation, GAP=3: with 5 words buffered, pulse rst_n low between edges →
  - dout_valid=0 and level=0 immediately (asynchronous);
  - no beat occurs after release until new words are written; the next beat is the first new word.
- TEST_DOUT_CNT_EN defined: rerun the streaming scenario → tx_count=16 at the end.
